// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU and its request arbiter.
package alu_pkg;

  localparam int unsigned ALU_W      = 4;
  localparam int unsigned ALU_OPW    = 4;
  localparam int unsigned ALU_MAX_OP = 9;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_MOD = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_AND = 4'd7,
    ALU_OR  = 4'd8,
    ALU_XOR = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one not granted last wins.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_id
);

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end
  end

  assign o_id = o_grant[1];

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one external ALU between two requesters with a valid/ready response.
// Optional per-requester response counters are built when ALU_ARB_STATS_EN is defined.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = ALU_W,
  parameter int unsigned OPW         = ALU_OPW,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned MAX_OP      = ALU_MAX_OP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_z,
  input  logic               alu_n,
  input  logic               alu_c,
  input  logic               alu_v,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [3:0]         rsp_flags,
  output logic               rsp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]         stat_cnt0,
  output logic [7:0]         stat_cnt1
`endif
);

  localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic             r_last;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_data;
  alu_flags_t       r_flags;
  logic             r_err;

  logic [1:0]       w_grant;
  logic             w_gnt_id;
  logic [1:0]       w_req_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [OPW-1:0]   w_sel_op;
  logic             w_legal;
  logic             w_rsp_hs;

  rr_arb2 u_rr_arb2 (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_id    (w_gnt_id)
  );

  assign w_req_ready = (r_state == IDLE) ? w_grant : 2'b00;
  assign w_xfer      = |(req_valid & w_req_ready);
  assign w_sel_a     = w_gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign w_sel_b     = w_gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign w_sel_op    = w_gnt_id ? req_op[2*OPW-1:OPW]    : req_op[OPW-1:0];
  assign w_legal     = (w_sel_op <= OPW'(MAX_OP));
  assign w_rsp_hs    = (r_state == RESP) && rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_xfer) w_state_nxt = w_legal ? EXEC : RESP;
      EXEC: if (r_cnt == '0) w_state_nxt = RESP;
      RESP: if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Illegal opcodes leave the ALU operand registers untouched so the ALU never sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_id    <= 1'b0;
      r_data  <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_id <= w_gnt_id;
            if (w_legal) begin
              r_a   <= w_sel_a;
              r_b   <= w_sel_b;
              r_op  <= w_sel_op;
              r_cnt <= CW'(EXEC_CYCLES - 1);
            end else begin
              r_data  <= '0;
              r_flags <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_data  <= alu_out;
            r_flags <= '{z: alu_z, n: alu_n, c: alu_c, v: alu_v};
            r_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) r_last <= r_id;
        default: ;
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_flags = r_flags;
  assign rsp_err   = r_err;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] r_stat0;
  logic [7:0] r_stat1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else if (w_rsp_hs) begin
      if (!r_id && r_stat0 != '1) r_stat0 <= r_stat0 + 8'd1;
      if (r_id && r_stat1 != '1)  r_stat1 <= r_stat1 + 8'd1;
    end
  end

  assign stat_cnt0 = r_stat0;
  assign stat_cnt1 = r_stat1;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_rsp_hs;
`endif

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the single 4-bit ALU (opcodes 0x0–0x9: ADD, SUB, MUL, DIV, MOD, SHL, SHR, AND, OR, XOR; flags Z/N/C/V) between two requesters, e.g. switch/button front end and a test sequencer.
- Round-robin arbitration, latches operands, drives the ALU, waits a programmable settle time, then returns the registered result plus flags over a valid/ready response channel.
- The ALU is instantiated beside this block, not inside it.

Parameters:
- WIDTH, 4, operand/result width
- OPW, 4, opcode width
- EXEC_CYCLES, 1, cycles the ALU inputs are held before result capture (≥1)
- MAX_OP, 9, highest legal opcode; above it = illegal

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept (one-hot or zero)
- req_a  in  2*WIDTH  operand A; requester i in [i*WIDTH +: WIDTH]
- req_b  in  2*WIDTH  operand B, same packing
- req_op  in  2*OPW  opcode, same packing
- alu_a  out  WIDTH  to ALU operand A
- alu_b  out  WIDTH  to ALU operand B
- alu_op  out  OPW  to ALU opcode
- alu_out  in  WIDTH  ALU result
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester that owns the response
- rsp_data  out  WIDTH  captured result
- rsp_flags  out  4  captured {Z,N,C,V}
- rsp_err  out  1  illegal opcode, ALU not used

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port `clk`, reset port `rst`.
- Reset: state IDLE; all outputs 0; alu_a/alu_b/alu_op regs 0; cycle counter 0; rr pointer = 1 (last granted = 1, so requester 0 wins the first tie).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = the requester with valid set; if both are valid, the one not last granted.
  - req_ready[grant] = 1 combinationally in the same cycle; the transfer occurs on req_valid & req_ready.
  - On transfer, latch a/b/op/id.
  - Legal opcode (≤ MAX_OP): go to EXEC, counter = EXEC_CYCLES-1.
  - Illegal opcode: go directly to RESP with rsp_err=1, rsp_data=0, rsp_flags=0.
- EXEC:
  - alu_a/b/op are driven only from the latched registers, so they are stable for the whole EXEC.
  - Counter decrements each cycle.
  - When the counter = 0, capture alu_out and flags into the rsp registers and go to RESP.
  - Latency from accept to rsp_valid = EXEC_CYCLES+1 cycles.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE, rr pointer = rsp_id, rsp_valid drops next cycle.
  - No new accept happens in the handshake cycle.
- req_ready is 0 in EXEC and RESP; requests are held off, not dropped. Requesters must keep valid and data stable until ready.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Simultaneous requests every cycle → strict alternation 0,1,0,1.
- A single active requester is granted back-to-back; no bubble other than the RESP→IDLE cycle.
- Reset mid-EXEC or mid-RESP aborts the operation; no response is issued.
- The ALU input registers retain the last operands in IDLE; alu_op is not forced to NOP.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs `stat_cnt0`, `stat_cnt1` (8 bits each). Each counts completed responses per requester (incl. errors), increments on the rsp handshake, saturates at 0xFF, and resets to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package `alu_pkg`:
  - `alu_op_e` enum for the 10 opcodes (ADD=0 … XOR=9)
  - `ALU_W`=4, `ALU_OPW`=4, `ALU_MAX_OP`=9
  - `arb_state_e` {IDLE, EXEC, RESP}
  - `alu_flags_t` packed struct {z,n,c,v}
- Sub-module `rr_arb2`: combinational 2-way round-robin grant from valid + last-grant bit. Everything else stays in the top.

Test Plan:
- Req0 ADD a=4'b1111 b=4'b1111 alone → req_ready[0] same cycle; rsp_valid after 2 cycles (EXEC_CYCLES=1); rsp_id=0, rsp_data=4'b1110, C=1, rsp_err=0.
- Req1 SUB a=4'b0000 b=4'b0001 → rsp_id=1, rsp_data=4'b1111, N=1; Z=0.
- Both valid continuously, ops AND 1&1 (req0) and OR 1|0 (req1), rsp_ready=1 → grant order 0,1,0,1; data 4'b0001 each.
- Req0 op=4'b1100 → no ALU capture; alu_op unchanged; rsp_err=1, rsp_data=0, rsp_flags=0, latency 1 cycle.
- Response held with rsp_ready=0 for 5 cycles while req1 is valid → rsp_* stable, req_ready=2'b00; req1 accepted 1 cycle after the handshake.
- Assert rst during EXEC of MUL 2*2 → outputs 0 immediately; no rsp_valid after release; the next request completes normally with 4'b0100.
